// File: rtl/freq_ctrl_pkg.sv
// Shared types and helpers for the frequency step controller.
//   state_t     : key FSM states
//   KEY_*       : bit positions in the key vector (clear > up > down)
//   FREQ_W      : frequency / offset width
//   clamp_freq  : saturate a wide signed value into [lo, hi]
package freq_ctrl_pkg;
  localparam int FREQ_W  = 32;
  localparam int KEY_CLR = 2;
  localparam int KEY_UP  = 1;
  localparam int KEY_DN  = 0;

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_RELEASE} state_t;

  // Two guard bits keep base + offset +/- step from ever wrapping.
  function automatic logic [FREQ_W-1:0] clamp_freq(
    input logic signed [FREQ_W+1:0] v,
    input logic        [FREQ_W-1:0] lo,
    input logic        [FREQ_W-1:0] hi
  );
    logic [FREQ_W-1:0] r;
    if (v < $signed({2'b00, lo}))      r = lo;
    else if (v > $signed({2'b00, hi})) r = hi;
    else                               r = v[FREQ_W-1:0];
    return r;
  endfunction
endpackage

// File: rtl/key_conditioner.sv
// Two-flop synchroniser plus whole-vector debounce for the raw key inputs.
//   clk, reset : clock, synchronous active-high reset
//   keys       : raw asynchronous buttons
//   kd         : debounced key vector; follows the synchronised vector once it
//                has held one value for DEBOUNCE_CYCLES consecutive cycles
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int W               = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] keys,
  output logic [W-1:0] kd
);
  localparam int             CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W:0] DEB   = (CNT_W+1)'(DEBOUNCE_CYCLES);

  logic [W-1:0]     s1_q, ks_q, ks_prev_q, kd_q, kd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   run_len;

  // run_len = cycles ks has held its present value, including this one.
  // The counter saturates at DEB so a long hold never wraps.
  always_comb begin
    run_len = (ks_q != ks_prev_q) ? (CNT_W+1)'(1) : {1'b0, cnt_q} + (CNT_W+1)'(1);
    kd_d    = kd_q;
    if (run_len >= DEB) begin
      cnt_d = DEB[CNT_W-1:0];
      kd_d  = ks_q;
    end else begin
      cnt_d = run_len[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      ks_q      <= '0;
      ks_prev_q <= '0;
      kd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= keys;
      ks_q      <= s1_q;
      ks_prev_q <= ks_q;
      kd_q      <= kd_d;
      cnt_q     <= cnt_d;
    end
  end

  assign kd = kd_q;
endmodule

// File: rtl/freq_step_controller.sv
// Turns debounced key presses into saturating frequency-offset steps with
// auto-repeat while a key is held.
//   clk, reset : clock, synchronous active-high reset
//   keys       : raw buttons [2]=clear [1]=up [0]=down
//   base_freq  : nominal frequency
//   new_freq   : clamp(base_freq + offset) to [MIN_FREQ, MAX_FREQ]
//   offset     : signed offset register
//   step_pulse : one-cycle strobe, one cycle after a step/clear lands in offset
//   at_limit   : new_freq sits on MIN_FREQ or MAX_FREQ
import freq_ctrl_pkg::*;

module freq_step_controller #(
  parameter int                STEP            = 500,
  parameter int                DEBOUNCE_CYCLES = 500000,
  parameter int                REPEAT_DELAY    = 25000000,
  parameter int                REPEAT_PERIOD   = 5000000,
  parameter logic [FREQ_W-1:0] MIN_FREQ        = 0,
  parameter logic [FREQ_W-1:0] MAX_FREQ        = 50000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               keys,
  input  logic [FREQ_W-1:0]        base_freq,
  output logic [FREQ_W-1:0]        new_freq,
  output logic signed [FREQ_W-1:0] offset,
  output logic                     step_pulse,
  output logic                     at_limit
);
  localparam int SW      = FREQ_W + 2;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic signed [SW-1:0] STEP_S = SW'(STEP);

  logic [2:0] kd;

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .W(3)) u_keys (
    .clk   (clk),
    .reset (reset),
    .keys  (keys),
    .kd    (kd)
  );

  state_t                    state_q, state_d;
  logic [1:0]                act_q, act_d;
  logic [RPT_W-1:0]          rpt_q, rpt_d;
  logic signed [FREQ_W-1:0]  offset_q, offset_d;
  logic [1:0]                vld_pipe_q;  // [0] lands with offset, [1] is the strobe
  logic                      apply;

  logic signed [SW-1:0]      cur_sum;
  logic [FREQ_W-1:0]         sat_up, sat_dn;
  logic signed [FREQ_W-1:0]  off_up, off_dn;

  assign cur_sum = $signed({2'b00, base_freq}) + $signed({{2{offset_q[FREQ_W-1]}}, offset_q});
  assign sat_up  = clamp_freq(cur_sum + STEP_S, MIN_FREQ, MAX_FREQ);
  assign sat_dn  = clamp_freq(cur_sum - STEP_S, MIN_FREQ, MAX_FREQ);
  // Offset is re-derived from the saturated target so it can never drift past a limit.
  assign off_up  = sat_up - base_freq;
  assign off_dn  = sat_dn - base_freq;

  assign new_freq   = clamp_freq(cur_sum, MIN_FREQ, MAX_FREQ);
  assign at_limit   = (new_freq == MIN_FREQ) || (new_freq == MAX_FREQ);
  assign offset     = offset_q;
  assign step_pulse = vld_pipe_q[1];

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    rpt_d    = rpt_q;
    offset_d = offset_q;
    apply    = 1'b0;
    case (state_q)
      IDLE: begin
        if (kd[KEY_CLR]) begin
          offset_d = '0;
          apply    = 1'b1;
          state_d  = WAIT_RELEASE;
        end else if (kd[KEY_UP] || kd[KEY_DN]) begin
          // Up outranks down; the latched key is the only one watched in HOLD.
          act_d    = kd[KEY_UP] ? 2'(KEY_UP) : 2'(KEY_DN);
          offset_d = kd[KEY_UP] ? off_up : off_dn;
          apply    = 1'b1;
          rpt_d    = RPT_W'(REPEAT_DELAY - 1);
          state_d  = HOLD;
        end
      end
      HOLD: begin
        // Dropping to IDLE on a higher-priority key lets IDLE service it next cycle.
        if (kd[KEY_CLR] || (act_q == 2'(KEY_DN) && kd[KEY_UP]) || !kd[act_q]) begin
          state_d = IDLE;
        end else if (rpt_q == '0) begin
          offset_d = (act_q == 2'(KEY_UP)) ? off_up : off_dn;
          apply    = 1'b1;
          rpt_d    = RPT_W'(REPEAT_PERIOD - 1);
        end else begin
          rpt_d = rpt_q - 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (kd == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      act_q      <= '0;
      rpt_q      <= '0;
      offset_q   <= '0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      rpt_q      <= rpt_d;
      offset_q   <= offset_d;
      vld_pipe_q <= {vld_pipe_q[0], apply};
    end
  end
endmodule

// File: tb/tb_freq_step_controller.sv
module tb_freq_step_controller;
  localparam int STEP = 500, DEB = 4, RD = 10, RP = 5, MINF = 0, MAXF = 2000;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [2:0]         keys = 3'b000;
  logic [31:0]        base_freq = 32'd1000;
  logic [31:0]        new_freq;
  logic signed [31:0] offset;
  logic               step_pulse, at_limit;

  int n_chk = 0, n_fail = 0;

  freq_step_controller #(
    .STEP(STEP), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .MIN_FREQ(MINF), .MAX_FREQ(MAXF)
  ) dut (
    .clk(clk), .reset(reset), .keys(keys), .base_freq(base_freq),
    .new_freq(new_freq), .offset(offset), .step_pulse(step_pulse), .at_limit(at_limit)
  );

  always #5 clk = ~clk;

  // Reference model: key history -> debounced keys -> press/hold behaviour,
  // with offset tracked as a plain integer.
  logic [2:0] m_s1 = 0, m_ks = 0, m_kd = 0;
  logic [2:0] m_hist[$];
  int         m_mode = 0;  // 0 idle, 1 holding, 2 waiting for release
  int         m_act = 0, m_since = 0;
  bit         m_first = 0, m_ev = 0, m_evt = 0, m_pulse = 0;
  longint     m_off = 0;

  function automatic longint clampf(longint v);
    return (v < MINF) ? MINF : (v > MAXF) ? MAXF : v;
  endfunction
  function automatic logic [31:0] exp_nf();
    longint b = base_freq;
    return 32'(clampf(b + m_off));
  endfunction
  function automatic logic exp_lim();
    return (exp_nf() == MINF) || (exp_nf() == MAXF);
  endfunction
  function automatic logic signed [31:0] exp_off();
    return 32'(m_off);
  endfunction

  task automatic m_step(bit up);
    longint b = base_freq;
    m_off = clampf(b + m_off + (up ? STEP : -STEP)) - b;
    m_ev  = 1;
  endtask

  task automatic tick();
    logic [2:0] kd_o;
    bit stable;
    @(posedge clk);
    if (reset) begin
      m_s1 = 0; m_ks = 0; m_kd = 0; m_hist.delete();
      m_mode = 0; m_off = 0; m_evt = 0; m_pulse = 0;
    end else begin
      kd_o = m_kd;
      m_ev = 0;
      m_hist.push_back(m_ks);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      stable = (m_hist.size() == DEB);
      foreach (m_hist[i]) if (m_hist[i] != m_ks) stable = 0;
      if (stable) m_kd = m_ks;
      m_ks = m_s1;
      m_s1 = keys;
      case (m_mode)
        0: if (kd_o[2]) begin
             m_off = 0; m_ev = 1; m_mode = 2;
           end else if (kd_o[1] || kd_o[0]) begin
             m_act = kd_o[1] ? 1 : 0;
             m_step(m_act == 1);
             m_since = 0; m_first = 1; m_mode = 1;
           end
        1: if (kd_o[2] || (m_act == 0 && kd_o[1]) || !kd_o[m_act]) m_mode = 0;
           else begin
             m_since++;
             if (m_since == (m_first ? RD : RP)) begin
               m_step(m_act == 1);
               m_since = 0; m_first = 0;
             end
           end
        default: if (kd_o == 3'b000) m_mode = 0;
      endcase
      m_pulse = m_evt;
      m_evt   = m_ev;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; keys = 0; base_freq = 1000;
    tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; keys = 3'b111; base_freq = 1000;
    tick(); tick();
    n_chk++;
    if (offset !== 0 || step_pulse !== 1'b0 || new_freq !== 1000 || at_limit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: off=%0d p=%b nf=%0d lim=%b, want 0 0 1000 0", offset, step_pulse, new_freq, at_limit);
    end
    keys = 0; reset = 0;
  endtask

  task automatic test_up_tap();
    int np = 0, pc = 0;
    keys = 3'b010;
    for (int i = 1; i <= 30; i++) begin
      if (i == 9) keys = 3'b000;
      tick();
      n_chk++;
      if ({step_pulse, at_limit, offset, new_freq} !== {m_pulse, exp_lim(), exp_off(), exp_nf()}) begin
        n_fail++;
        $display("FAIL tap cyc %0d: got p=%b lim=%b off=%0d nf=%0d, want p=%b lim=%b off=%0d nf=%0d",
                 i, step_pulse, at_limit, offset, new_freq, m_pulse, exp_lim(), exp_off(), exp_nf());
      end
      if (step_pulse === 1'b1) begin np++; pc = i; end
    end
    n_chk++;
    if (np != 1 || pc != 8) begin
      n_fail++; $display("FAIL tap_latency: %0d pulses, last at cycle %0d, want 1 at cycle 8", np, pc);
    end
    n_chk++;
    if (offset !== 500 || new_freq !== 1500) begin
      n_fail++; $display("FAIL tap_value: off=%0d nf=%0d, want 500 1500", offset, new_freq);
    end
  endtask

  task automatic test_up_hold();
    int pcs[$];
    do_reset();
    keys = 3'b010;
    for (int i = 1; i <= 70; i++) begin
      if (i == 41) keys = 3'b000;
      tick();
      n_chk++;
      if ({step_pulse, at_limit, offset, new_freq} !== {m_pulse, exp_lim(), exp_off(), exp_nf()}) begin
        n_fail++;
        $display("FAIL hold cyc %0d: got p=%b lim=%b off=%0d nf=%0d, want p=%b lim=%b off=%0d nf=%0d",
                 i, step_pulse, at_limit, offset, new_freq, m_pulse, exp_lim(), exp_off(), exp_nf());
      end
      if (step_pulse === 1'b1) pcs.push_back(i);
    end
    n_chk++;
    if (pcs.size() != 7 || pcs[0] != 8 || pcs[1] != 18 || pcs[2] != 23) begin
      n_fail++;
      $display("FAIL hold_repeat: %0d pulses, first three at %0d %0d %0d, want 7 at 8 18 23",
               pcs.size(), (pcs.size() > 0) ? pcs[0] : -1, (pcs.size() > 1) ? pcs[1] : -1,
               (pcs.size() > 2) ? pcs[2] : -1);
    end
    n_chk++;
    if (offset !== 1000 || new_freq !== 2000 || at_limit !== 1'b1) begin
      n_fail++; $display("FAIL hold_sat: off=%0d nf=%0d lim=%b, want 1000 2000 1", offset, new_freq, at_limit);
    end
  endtask

  task automatic test_bounce();
    int np = 0, pc = 0;
    do_reset();
    for (int i = 1; i <= 60; i++) begin
      if (i <= 20)      keys = (((i - 1) / 2) % 2 == 0) ? 3'b001 : 3'b000;
      else if (i <= 30) keys = 3'b001;
      else              keys = 3'b000;
      tick();
      n_chk++;
      if ({step_pulse, at_limit, offset, new_freq} !== {m_pulse, exp_lim(), exp_off(), exp_nf()}) begin
        n_fail++;
        $display("FAIL bounce cyc %0d: got p=%b lim=%b off=%0d nf=%0d, want p=%b lim=%b off=%0d nf=%0d",
                 i, step_pulse, at_limit, offset, new_freq, m_pulse, exp_lim(), exp_off(), exp_nf());
      end
      if (step_pulse === 1'b1) begin np++; pc = i; end
    end
    n_chk++;
    if (np != 1 || pc != 28 || new_freq !== 500) begin
      n_fail++; $display("FAIL bounce_step: %0d pulses last at %0d nf=%0d, want 1 at 28 nf=500", np, pc, new_freq);
    end
  endtask

  task automatic test_clear_hold();
    int  np = 0;
    bit  hit = 0;
    do_reset();
    keys = 3'b010;
    for (int i = 1; i <= 60 && !hit; i++) begin
      tick();
      n_chk++;
      if ({step_pulse, at_limit, offset, new_freq} !== {m_pulse, exp_lim(), exp_off(), exp_nf()}) begin
        n_fail++;
        $display("FAIL clear_pre cyc %0d: got p=%b lim=%b off=%0d nf=%0d, want p=%b lim=%b off=%0d nf=%0d",
                 i, step_pulse, at_limit, offset, new_freq, m_pulse, exp_lim(), exp_off(), exp_nf());
      end
      if (new_freq === 2000) hit = 1;
    end
    n_chk++;
    if (!hit) begin n_fail++; $display("FAIL clear_reach_max: nf=%0d after 60 cycles, want 2000", new_freq); end
    for (int i = 1; i <= 70; i++) begin
      if (i == 1)  keys = 3'b110;
      if (i == 21) keys = 3'b000;
      if (i == 41) keys = 3'b010;
      if (i == 49) keys = 3'b000;
      tick();
      n_chk++;
      if ({step_pulse, at_limit, offset, new_freq} !== {m_pulse, exp_lim(), exp_off(), exp_nf()}) begin
        n_fail++;
        $display("FAIL clear cyc %0d: got p=%b lim=%b off=%0d nf=%0d, want p=%b lim=%b off=%0d nf=%0d",
                 i, step_pulse, at_limit, offset, new_freq, m_pulse, exp_lim(), exp_off(), exp_nf());
      end
      if (i > 10 && i <= 40 && step_pulse === 1'b1) np++;
      if (i == 20) begin
        n_chk++;
        if (offset !== 0 || new_freq !== 1000) begin
          n_fail++; $display("FAIL clear_value: off=%0d nf=%0d, want 0 1000", offset, new_freq);
        end
      end
    end
    n_chk++;
    if (np != 0) begin n_fail++; $display("FAIL clear_no_repeat: %0d pulses after clear, want 0", np); end
    n_chk++;
    if (offset !== 500) begin n_fail++; $display("FAIL clear_new_press: off=%0d, want 500", offset); end
  endtask

  task automatic test_reset_mid_hold();
    int pc = 0;
    do_reset();
    keys = 3'b010;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_chk++;
      if ({step_pulse, at_limit, offset, new_freq} !== {m_pulse, exp_lim(), exp_off(), exp_nf()}) begin
        n_fail++;
        $display("FAIL rsthold_pre cyc %0d: got p=%b off=%0d nf=%0d, want p=%b off=%0d nf=%0d",
                 i, step_pulse, offset, new_freq, m_pulse, exp_off(), exp_nf());
      end
    end
    reset = 1; tick(); reset = 0;
    n_chk++;
    if (offset !== 0 || step_pulse !== 1'b0 || new_freq !== 1000) begin
      n_fail++; $display("FAIL rsthold_clear: off=%0d p=%b nf=%0d, want 0 0 1000", offset, step_pulse, new_freq);
    end
    for (int j = 1; j <= 20; j++) begin
      if (j == 12) keys = 3'b000;
      tick();
      n_chk++;
      if ({step_pulse, at_limit, offset, new_freq} !== {m_pulse, exp_lim(), exp_off(), exp_nf()}) begin
        n_fail++;
        $display("FAIL rsthold cyc %0d: got p=%b off=%0d nf=%0d, want p=%b off=%0d nf=%0d",
                 j, step_pulse, offset, new_freq, m_pulse, exp_off(), exp_nf());
      end
      if (step_pulse === 1'b1 && pc == 0) pc = j;
    end
    n_chk++;
    if (pc != 8) begin n_fail++; $display("FAIL rsthold_latency: first pulse at %0d, want 8", pc); end
  endtask

  task automatic test_base_change();
    do_reset();
    keys = 3'b010;
    for (int i = 1; i <= 28; i++) begin
      if (i == 9) keys = 3'b000;
      tick();
    end
    base_freq = 1800;
    tick();
    n_chk++;
    if (new_freq !== 2000 || at_limit !== 1'b1 || offset !== 500) begin
      n_fail++; $display("FAIL base_clamp: nf=%0d lim=%b off=%0d, want 2000 1 500", new_freq, at_limit, offset);
    end
    base_freq = 1000;
    tick();
    n_chk++;
    if (new_freq !== 1500 || at_limit !== 1'b0) begin
      n_fail++; $display("FAIL base_restore: nf=%0d lim=%b, want 1500 0", new_freq, at_limit);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    do_reset();
    for (int i = 1; i <= 900; i++) begin
      if (hold == 0) begin
        keys = 3'($urandom_range(0, 7));
        hold = $urandom_range(1, 25);
        if ($urandom_range(0, 7) == 0) base_freq = $urandom_range(0, 2600);
      end
      hold--;
      reset = ($urandom_range(0, 299) == 0);
      tick();
      n_chk++;
      if ({step_pulse, at_limit, offset, new_freq} !== {m_pulse, exp_lim(), exp_off(), exp_nf()}) begin
        n_fail++;
        $display("FAIL random cyc %0d: got p=%b lim=%b off=%0d nf=%0d, want p=%b lim=%b off=%0d nf=%0d",
                 i, step_pulse, at_limit, offset, new_freq, m_pulse, exp_lim(), exp_off(), exp_nf());
      end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_up_tap();
    test_up_hold();
    test_bounce();
    test_clear_hold();
    test_reset_mid_hold();
    test_base_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
